// File: rtl/fifo_sync_param.sv
// Synchronous single-clock FIFO with registered read data, registered
// occupancy flags, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow error flags.
module fifo_sync_param #(
  parameter int DW        = 40,
  parameter int AW        = 8,
  parameter int AF_THRESH = 240,
  parameter int AE_THRESH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] din,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_THRESH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_over;
  logic          r_under;
  logic [DW-1:0] r_dout;
  logic          r_dv;

  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [AW:0]   w_count_nxt;

  // Accept decisions use the registered flags, so a full FIFO can still be
  // read and an empty FIFO can still be written in the same cycle.
  always_comb begin
    w_wr_ok     = we & ~r_full;
    w_rd_ok     = re & ~r_empty;
    w_count_nxt = r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
  end

  // Storage array: plain write port with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !clr) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Pointers, occupancy, flags and sticky errors; clear outranks we/re.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else if (clr) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_over   <= 1'b0;
      r_under  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == DEPTH_C);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= AF_C);
      r_aempty <= (w_count_nxt <= AE_C);
      if (we && r_full) begin
        r_over <= 1'b1;
      end
      if (re && r_empty) begin
        r_under <= 1'b1;
      end
    end
  end

  // Registered read port: dout holds its value between accepted reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      r_dv   <= 1'b0;
    end else if (clr) begin
      r_dv   <= 1'b0;
    end else begin
      r_dv <= w_rd_ok;
      if (w_rd_ok) begin
        r_dout <= r_mem[r_rptr];
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dv;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_over;
  assign underflow    = r_under;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param using a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 40;
  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int AF    = 240;
  localparam int AE    = 16;
  localparam int SW    = AW + 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [DW-1:0] din;
  logic          we;
  logic          re;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_dout;
  logic          m_dv;
  logic          m_ov;
  logic          m_un;

  logic [SW-1:0] dut_status;

  fifo_sync_param #(.DW(DW), .AW(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .clr(clr), .din(din), .we(we), .re(re),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  assign dut_status = {count, full, empty, almost_full, almost_empty, overflow, underflow, dout_valid};

  // Expected status word from occupancy of the model queue.
  function automatic logic [SW-1:0] exp_status();
    int n;
    n = mq.size();
    return {(AW+1)'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ov, m_un, m_dv};
  endfunction

  function automatic logic [DW-1:0] rand_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  // One clock: drive inputs, advance the model from pre-edge state, then wait.
  task automatic cycle(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
    logic f;
    logic e;
    we = w; re = r; clr = c; din = d;
    if (c) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_dv = 1'b0;
    end else begin
      f = (mq.size() == DEPTH);
      e = (mq.size() == 0);
      m_dv = r && !e;
      if (r && !e) m_dout = mq.pop_front();
      if (w && !f) mq.push_back(d);
      if (w && f) m_ov = 1'b1;
      if (r && e) m_un = 1'b1;
    end
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    mq.delete(); m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_status !== exp_status()) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h expected %h", dut_status, exp_status());
    end
    checks++;
    if (dout !== '0) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %h expected 0", dout);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 1'b0, DW'(i));
    checks++;
    if (count !== 3) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d expected 3", count);
    end
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (dout !== DW'(i) || dout_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL basic_read%0d: got %h/%b expected %h/1", i, dout, dout_valid, DW'(i));
      end
    end
    cycle(1'b0, 1'b0, 1'b0, '0);
    checks++;
    if (dut_status !== exp_status()) begin
      errors++;
      $display("[TB] FAIL basic_empty: got %h expected %h", dut_status, exp_status());
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 1'b0, rand_word());
      checks++;
      if (dut_status !== exp_status()) begin
        errors++;
        $display("[TB] FAIL fill_status n=%0d: got %h expected %h", mq.size(), dut_status, exp_status());
      end
      if (mq.size() == AF - 1 || mq.size() == AF) begin
        checks++;
        if (almost_full !== (mq.size() == AF)) begin
          errors++;
          $display("[TB] FAIL fill_af n=%0d: got %b", mq.size(), almost_full);
        end
      end
    end
    cycle(1'b1, 1'b0, 1'b0, rand_word());
    checks++;
    if (count !== 256 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow: got count=%0d full=%b ov=%b expected 256/1/1", count, full, overflow);
    end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] first;
    first = mq[0];
    cycle(1'b1, 1'b1, 1'b0, rand_word());
    checks++;
    if (count !== 255 || full !== 1'b0 || overflow !== 1'b1 || dout !== first) begin
      errors++;
      $display("[TB] FAIL full_rw: got count=%0d full=%b ov=%b dout=%h expected 255/0/1/%h",
               count, full, overflow, dout, first);
    end
    while (mq.size() > 0) begin
      cycle(1'b0, 1'b1, 1'b0, '0);
      checks++;
      if (dout !== m_dout || dut_status !== exp_status()) begin
        errors++;
        $display("[TB] FAIL drain: got %h/%h expected %h/%h", dout, dut_status, m_dout, exp_status());
      end
    end
  endtask

  task automatic test_empty_underflow();
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (underflow !== 1'b1 || dout_valid !== 1'b0 || dut_status !== exp_status()) begin
      errors++;
      $display("[TB] FAIL underflow: got un=%b dv=%b status=%h expected 1/0/%h",
               underflow, dout_valid, dut_status, exp_status());
    end
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b0, rand_word());
    checks++;
    if (count !== 1 || underflow !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_rw: got count=%0d un=%b dv=%b expected 1/1/0", count, underflow, dout_valid);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (dout !== m_dout || dut_status !== exp_status()) begin
      errors++;
      $display("[TB] FAIL empty_rw_read: got %h/%h expected %h/%h", dout, dut_status, m_dout, exp_status());
    end
  endtask

  task automatic test_stream();
    int wr_cnt;
    int rd_cnt;
    int cyc;
    logic w;
    logic r;
    wr_cnt = 0; rd_cnt = 0; cyc = 0;
    cycle(1'b0, 1'b0, 1'b1, '0);
    while (rd_cnt < 1000 && cyc < 20000) begin
      w = (wr_cnt < 1000) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (w && mq.size() != DEPTH) wr_cnt++;
      cycle(w, r, 1'b0, rand_word());
      cyc++;
      if (m_dv) begin
        rd_cnt++;
        checks++;
        if (dout !== m_dout) begin
          errors++;
          $display("[TB] FAIL stream_data #%0d: got %h expected %h", rd_cnt, dout, m_dout);
        end
      end
      checks++;
      if (dut_status !== exp_status() || count > 256) begin
        errors++;
        $display("[TB] FAIL stream_status cyc=%0d: got %h expected %h", cyc, dut_status, exp_status());
      end
    end
    checks++;
    if (rd_cnt != 1000) begin
      errors++;
      $display("[TB] FAIL stream_budget: got %0d words read expected 1000", rd_cnt);
    end
  endtask

  task automatic test_clear();
    cycle(1'b0, 1'b0, 1'b1, '0);
    while (mq.size() < DEPTH) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b1, 1'b0, 1'b0, rand_word());
    while (mq.size() > 10) cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (count !== 10 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_setup: got count=%0d ov=%b expected 10/1", count, overflow);
    end
    cycle(1'b0, 1'b0, 1'b1, '0);
    checks++;
    if (dut_status !== exp_status() || dout !== m_dout) begin
      errors++;
      $display("[TB] FAIL clear: got %h/%h expected %h/%h", dut_status, dout, exp_status(), m_dout);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, rand_word());
    cycle(1'b0, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b0;
    mq.delete(); m_dout = '0; m_dv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
    #1;
    checks++;
    if (dut_status !== exp_status() || dout !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h/%h expected %h/0", dut_status, dout, exp_status());
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    a = rand_word();
    b = rand_word();
    cycle(1'b1, 1'b0, 1'b0, a);
    cycle(1'b1, 1'b1, 1'b0, b);
    checks++;
    if (dout !== a || dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset_a: got %h expected %h", dout, a);
    end
    cycle(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (dout !== b || dut_status !== exp_status()) begin
      errors++;
      $display("[TB] FAIL post_reset_b: got %h/%h expected %h/%h", dout, dut_status, b, exp_status());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_full_rw();
    test_empty_underflow();
    test_stream();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
